// File: rtl/main_control_fsm.sv
// Multicycle main control FSM for the RV32 core: sequences fetch/decode/execute/
// memory/writeback, drives ALUOP into the ALU decoder and the datapath selects/enables.
`timescale 1ns/1ps
module main_control_fsm #(
  parameter logic [2:0] ALUOP_ADD   = 3'b000,
  parameter logic [2:0] ALUOP_SUB   = 3'b001,
  parameter logic [2:0] ALUOP_FUNCT = 3'b111
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic [2:0] ALUOP,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       AdrSrc,
  output logic [1:0] ImmSrc,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       illegal_op,
  output logic       instr_done,
  output logic [3:0] state
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  state_t state_r;
  state_t state_nxt;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= S_FETCH;
    else        state_r <= state_nxt;
  end

  assign state = 4'(state_r);

  // Next-state and control decode
  always_comb begin
    state_nxt  = S_FETCH;
    ALUOP      = ALUOP_ADD;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    AdrSrc     = 1'b0;
    ImmSrc     = 2'b00;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    RegWrite   = 1'b0;
    MemWrite   = 1'b0;
    illegal_op = 1'b0;
    instr_done = 1'b0;

    case (op)
      OP_SW:   ImmSrc = 2'b01;
      OP_BEQ:  ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase

    case (state_r)
      S_FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = mem_ready;
        PCWrite   = mem_ready;
        state_nxt = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OP_LW, OP_SW: state_nxt = S_MEMADR;
          OP_R:         state_nxt = S_EXECUTER;
          OP_I:         state_nxt = S_EXECUTEI;
          OP_BEQ:       state_nxt = S_BEQ;
          OP_JAL:       state_nxt = S_JAL;
          default: begin
            state_nxt  = S_FETCH;
            illegal_op = 1'b1;
            instr_done = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b01;
        state_nxt = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        AdrSrc    = 1'b1;
        state_nxt = mem_ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        ResultSrc  = 2'b01;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc     = 1'b1;
        MemWrite   = 1'b1;
        instr_done = mem_ready;
        state_nxt  = mem_ready ? S_FETCH : S_MEMWRITE;
      end
      S_EXECUTER: begin
        ALUSrcA   = 2'b10;
        ALUOP     = ALUOP_FUNCT;
        state_nxt = S_ALUWB;
      end
      S_EXECUTEI: begin
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b01;
        ALUOP     = ALUOP_FUNCT;
        state_nxt = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA    = 2'b10;
        ALUOP      = ALUOP_SUB;
        PCWrite    = Zero;
        instr_done = 1'b1;
      end
      S_JAL: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        PCWrite   = 1'b1;
        state_nxt = S_ALUWB;
      end
      default: state_nxt = S_FETCH;
    endcase

    // Reset must kill every enable at once, including the mem_ready-driven ones in FETCH
    if (!rst_n) begin
      IRWrite    = 1'b0;
      PCWrite    = 1'b0;
      RegWrite   = 1'b0;
      MemWrite   = 1'b0;
      illegal_op = 1'b0;
      instr_done = 1'b0;
    end
  end

endmodule

// File: tb/tb_main_control_fsm.sv
// Scoreboard bench for main_control_fsm: per-cycle expectations queued with the
// stimulus and compared against the DUT outputs mid-cycle.
`timescale 1ns/1ps
module tb_main_control_fsm;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  typedef struct packed {
    logic [3:0] st;
    logic [2:0] aluop;
    logic [1:0] sa;
    logic [1:0] sb;
    logic [1:0] rs;
    logic       adr;
    logic [5:0] we;  // {IRWrite, PCWrite, RegWrite, MemWrite, illegal_op, instr_done}
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [6:0] op;
  logic       Zero;
  logic       mem_ready;
  logic [2:0] ALUOP;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, ImmSrc;
  logic       AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite, illegal_op, instr_done;
  logic [3:0] state;

  int n_total = 0;
  int n_bad   = 0;
  exp_t sb_q[$];

  main_control_fsm dut (
    .clk(clk), .rst_n(rst_n), .op(op), .Zero(Zero), .mem_ready(mem_ready),
    .ALUOP(ALUOP), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
    .AdrSrc(AdrSrc), .ImmSrc(ImmSrc), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .RegWrite(RegWrite), .MemWrite(MemWrite), .illegal_op(illegal_op),
    .instr_done(instr_done), .state(state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic exp_t ex(input logic [3:0] st, input logic [2:0] aluop,
                              input logic [1:0] sa, input logic [1:0] sb,
                              input logic [1:0] rs, input logic adr, input logic [5:0] we);
    exp_t e;
    e.st = st; e.aluop = aluop; e.sa = sa; e.sb = sb; e.rs = rs; e.adr = adr; e.we = we;
    return e;
  endfunction

  // Drive one cycle's inputs at the falling edge, queue its expectation, compare mid-cycle
  task automatic step(input logic [6:0] o, input logic mr, input logic z, input exp_t e);
    exp_t got;
    @(negedge clk);
    op = o; mem_ready = mr; Zero = z;
    sb_q.push_back(e);
    #1;
    check("sb_depth", 32'(sb_q.size()), 32'd1);
    got = sb_q.pop_front();
    check("state",     32'(state),     32'(got.st));
    check("ALUOP",     32'(ALUOP),     32'(got.aluop));
    check("ALUSrcA",   32'(ALUSrcA),   32'(got.sa));
    check("ALUSrcB",   32'(ALUSrcB),   32'(got.sb));
    check("ResultSrc", 32'(ResultSrc), 32'(got.rs));
    check("AdrSrc",    32'(AdrSrc),    32'(got.adr));
    check("enables",   32'({IRWrite, PCWrite, RegWrite, MemWrite, illegal_op, instr_done}),
          32'(got.we));
  endtask

  initial begin
    rst_n = 1'b0; op = OP_R; Zero = 1'b0; mem_ready = 1'b1;

    // Held in reset: FETCH selects, enables forced low even with mem_ready=1
    step(OP_R, 1, 0, ex(4'd0, 3'b000, 2'b00, 2'b10, 2'b10, 0, 6'b000000));
    step(OP_R, 0, 0, ex(4'd0, 3'b000, 2'b00, 2'b10, 2'b10, 0, 6'b000000));
    rst_n = 1'b1;

    // R-type: 0,1,6,8
    step(OP_R, 1, 0, ex(4'd0, 3'b000, 2'b00, 2'b10, 2'b10, 0, 6'b110000));
    check("imm_r", 32'(ImmSrc), 32'd0);
    step(OP_R, 1, 0, ex(4'd1, 3'b000, 2'b01, 2'b01, 2'b00, 0, 6'b000000));
    step(OP_R, 1, 0, ex(4'd6, 3'b111, 2'b10, 2'b00, 2'b00, 0, 6'b000000));
    step(OP_R, 1, 0, ex(4'd8, 3'b000, 2'b00, 2'b00, 2'b00, 0, 6'b001001));

    // lw with two stall cycles in MEMREAD: 0,1,2,3,3,3,4
    step(OP_LW, 1, 0, ex(4'd0, 3'b000, 2'b00, 2'b10, 2'b10, 0, 6'b110000));
    step(OP_LW, 1, 0, ex(4'd1, 3'b000, 2'b01, 2'b01, 2'b00, 0, 6'b000000));
    step(OP_LW, 1, 0, ex(4'd2, 3'b000, 2'b10, 2'b01, 2'b00, 0, 6'b000000));
    step(OP_LW, 0, 0, ex(4'd3, 3'b000, 2'b00, 2'b00, 2'b00, 1, 6'b000000));
    step(OP_LW, 0, 0, ex(4'd3, 3'b000, 2'b00, 2'b00, 2'b00, 1, 6'b000000));
    step(OP_LW, 1, 0, ex(4'd3, 3'b000, 2'b00, 2'b00, 2'b00, 1, 6'b000000));
    step(OP_LW, 1, 0, ex(4'd4, 3'b000, 2'b00, 2'b00, 2'b01, 0, 6'b001001));

    // sw with a fetch stall and one MEMWRITE stall: MemWrite for exactly 2 cycles
    step(OP_SW, 0, 0, ex(4'd0, 3'b000, 2'b00, 2'b10, 2'b10, 0, 6'b000000));
    check("imm_s", 32'(ImmSrc), 32'd1);
    step(OP_SW, 1, 0, ex(4'd0, 3'b000, 2'b00, 2'b10, 2'b10, 0, 6'b110000));
    step(OP_SW, 1, 0, ex(4'd1, 3'b000, 2'b01, 2'b01, 2'b00, 0, 6'b000000));
    step(OP_SW, 1, 0, ex(4'd2, 3'b000, 2'b10, 2'b01, 2'b00, 0, 6'b000000));
    step(OP_SW, 0, 0, ex(4'd5, 3'b000, 2'b00, 2'b00, 2'b00, 1, 6'b000100));
    step(OP_SW, 1, 0, ex(4'd5, 3'b000, 2'b00, 2'b00, 2'b00, 1, 6'b000101));

    // beq taken then not taken
    step(OP_BEQ, 1, 1, ex(4'd0, 3'b000, 2'b00, 2'b10, 2'b10, 0, 6'b110000));
    check("imm_b", 32'(ImmSrc), 32'd2);
    step(OP_BEQ, 1, 1, ex(4'd1, 3'b000, 2'b01, 2'b01, 2'b00, 0, 6'b000000));
    step(OP_BEQ, 1, 1, ex(4'd9, 3'b001, 2'b10, 2'b00, 2'b00, 0, 6'b010001));
    step(OP_BEQ, 1, 0, ex(4'd0, 3'b000, 2'b00, 2'b10, 2'b10, 0, 6'b110000));
    step(OP_BEQ, 1, 0, ex(4'd1, 3'b000, 2'b01, 2'b01, 2'b00, 0, 6'b000000));
    step(OP_BEQ, 1, 0, ex(4'd9, 3'b001, 2'b10, 2'b00, 2'b00, 0, 6'b000001));

    // Illegal opcode: two cycles, pulse in DECODE
    step(OP_BAD, 1, 0, ex(4'd0, 3'b000, 2'b00, 2'b10, 2'b10, 0, 6'b110000));
    check("imm_bad", 32'(ImmSrc), 32'd0);
    step(OP_BAD, 1, 0, ex(4'd1, 3'b000, 2'b01, 2'b01, 2'b00, 0, 6'b000011));

    // jal: 0,1,10,8
    step(OP_JAL, 1, 0, ex(4'd0, 3'b000, 2'b00, 2'b10, 2'b10, 0, 6'b110000));
    check("imm_j", 32'(ImmSrc), 32'd3);
    step(OP_JAL, 1, 0, ex(4'd1, 3'b000, 2'b01, 2'b01, 2'b00, 0, 6'b000000));
    step(OP_JAL, 1, 0, ex(4'd10, 3'b000, 2'b01, 2'b10, 2'b00, 0, 6'b010000));
    step(OP_JAL, 1, 0, ex(4'd8, 3'b000, 2'b00, 2'b00, 2'b00, 0, 6'b001001));

    // I-type: 0,1,7,8
    step(OP_I, 1, 0, ex(4'd0, 3'b000, 2'b00, 2'b10, 2'b10, 0, 6'b110000));
    step(OP_I, 1, 0, ex(4'd1, 3'b000, 2'b01, 2'b01, 2'b00, 0, 6'b000000));
    step(OP_I, 1, 0, ex(4'd7, 3'b111, 2'b10, 2'b01, 2'b00, 0, 6'b000000));
    step(OP_I, 1, 0, ex(4'd8, 3'b000, 2'b00, 2'b00, 2'b00, 0, 6'b001001));

    // sw aborted by reset while stalled in MEMWRITE
    step(OP_SW, 1, 0, ex(4'd0, 3'b000, 2'b00, 2'b10, 2'b10, 0, 6'b110000));
    step(OP_SW, 1, 0, ex(4'd1, 3'b000, 2'b01, 2'b01, 2'b00, 0, 6'b000000));
    step(OP_SW, 1, 0, ex(4'd2, 3'b000, 2'b10, 2'b01, 2'b00, 0, 6'b000000));
    step(OP_SW, 0, 0, ex(4'd5, 3'b000, 2'b00, 2'b00, 2'b00, 1, 6'b000100));
    #2;
    rst_n = 1'b0;
    mem_ready = 1'b1;
    #1;
    check("abort_state", 32'(state), 32'd0);
    check("abort_memwrite", 32'(MemWrite), 32'd0);
    check("abort_adrsrc", 32'(AdrSrc), 32'd0);
    check("abort_enables",
          32'({IRWrite, PCWrite, RegWrite, MemWrite, illegal_op, instr_done}), 32'd0);
    mem_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // After release FETCH waits for mem_ready
    step(OP_SW, 0, 0, ex(4'd0, 3'b000, 2'b00, 2'b10, 2'b10, 0, 6'b000000));
    step(OP_SW, 0, 0, ex(4'd0, 3'b000, 2'b00, 2'b10, 2'b10, 0, 6'b000000));
    step(OP_SW, 1, 0, ex(4'd0, 3'b000, 2'b00, 2'b10, 2'b10, 0, 6'b110000));
    step(OP_SW, 1, 0, ex(4'd1, 3'b000, 2'b01, 2'b01, 2'b00, 0, 6'b000000));

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
